// File: rtl/sdram_pattern_tester_if.sv
// Processor-side request port of the SDRAM controller, seen from the pattern tester.
// No logic of its own; strobes and the returned data travel through it combinationally.
// mem_busy_i holds off new strobes, and mem_ack_i completes the single outstanding request.
interface sdram_pattern_tester_if #(
  parameter int ADDR_WIDTH = 25
);
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [15:0]           mem_data_o;
  logic                  mem_we_o;
  logic                  mem_re_o;
  logic [15:0]           mem_data_i;
  logic                  mem_ack_i;
  logic                  mem_busy_i;

  modport master (
    output mem_addr_o, mem_data_o, mem_we_o, mem_re_o,
    input  mem_data_i, mem_ack_i, mem_busy_i
  );

  modport slave (
    input  mem_addr_o, mem_data_o, mem_we_o, mem_re_o,
    output mem_data_i, mem_ack_i, mem_busy_i
  );
endinterface

// File: rtl/sdram_pattern_tester.sv
// Writes a pattern over an inclusive address range, reads it back, and counts mismatches.
// Each word takes at least 2 cycles per phase; the compare result is registered 1 cycle after the read ack.
// A strobe is issued only in a cycle where mem_busy_i is low; a missing ack ends the test after ACK_TIMEOUT cycles.
module sdram_pattern_tester #(
  parameter int ADDR_WIDTH  = 25,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [1:0]            pattern_sel_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH-1:0] end_addr_i,
  sdram_pattern_tester_if.master mem,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [15:0]           err_count_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic [15:0]           first_err_data_o
);

  localparam int          TW        = $clog2(ACK_TIMEOUT + 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {IDLE, W_REQ, W_WAIT, R_REQ, R_WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, start_q, end_q;
  logic [1:0]            sel_q;
  logic [15:0]           lfsr_q, lfsr_next, pat;
  logic [TW-1:0]         tcnt_q;
  logic [15:0]           err_q;
  logic [ADDR_WIDTH-1:0] ferr_addr_q;
  logic [15:0]           ferr_data_q;
  logic                  timeout_q;
  logic                  we, re, accept, step, rewind, cmp_en, to_hit;
  logic                  is_last, ack_expired;

  // The last-word test uses equality before the increment, so an all-ones end address cannot wrap.
  assign is_last     = (addr_q == end_q);
  assign ack_expired = (tcnt_q == TW'(ACK_TIMEOUT - 1));
  assign lfsr_next   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  // Generate the data word for the current address in the selected pattern.
  always_comb begin
    pat = 16'h0000;
    unique case (sel_q)
      2'd0:    pat = addr_q[15:0];
      2'd1:    pat = ~addr_q[15:0];
      2'd2:    pat = lfsr_q;
      default: pat = addr_q[0] ? 16'h5555 : 16'hAAAA;
    endcase
  end

  // Compute the next state and the one-cycle control pulses that drive the datapath.
  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    re      = 1'b0;
    accept  = 1'b0;
    step    = 1'b0;
    rewind  = 1'b0;
    cmp_en  = 1'b0;
    to_hit  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = (end_addr_i < start_addr_i) ? DONE : W_REQ;
        end
      end
      W_REQ: begin
        if (!mem.mem_busy_i) begin
          we      = 1'b1;
          state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (mem.mem_ack_i) begin
          if (is_last) begin
            rewind  = 1'b1;
            state_d = R_REQ;
          end else begin
            step    = 1'b1;
            state_d = W_REQ;
          end
        end else if (ack_expired) begin
          to_hit  = 1'b1;
          state_d = DONE;
        end
      end
      R_REQ: begin
        if (!mem.mem_busy_i) begin
          re      = 1'b1;
          state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (mem.mem_ack_i) begin
          cmp_en = 1'b1;
          if (is_last) begin
            state_d = DONE;
          end else begin
            step    = 1'b1;
            state_d = R_REQ;
          end
        end else if (ack_expired) begin
          to_hit  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold the FSM state register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Update the address, LFSR, ack timer, and result registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      start_q     <= '0;
      end_q       <= '0;
      sel_q       <= 2'd0;
      lfsr_q      <= 16'h0000;
      tcnt_q      <= '0;
      err_q       <= 16'h0000;
      ferr_addr_q <= '0;
      ferr_data_q <= 16'h0000;
      timeout_q   <= 1'b0;
    end else begin
      if (accept) begin
        start_q     <= start_addr_i;
        end_q       <= end_addr_i;
        sel_q       <= pattern_sel_i;
        addr_q      <= start_addr_i;
        lfsr_q      <= LFSR_SEED;
        err_q       <= 16'h0000;
        ferr_addr_q <= '0;
        ferr_data_q <= 16'h0000;
        timeout_q   <= 1'b0;
      end
      if (rewind) begin
        addr_q <= start_q;
        lfsr_q <= LFSR_SEED;
      end
      if (step) begin
        addr_q <= addr_q + 1'b1;
        lfsr_q <= lfsr_next;
      end
      if (we || re) tcnt_q <= '0;
      else if (state_q == W_WAIT || state_q == R_WAIT) tcnt_q <= tcnt_q + TW'(1);
      if (to_hit) timeout_q <= 1'b1;
      if (cmp_en && (mem.mem_data_i != pat)) begin
        if (err_q == 16'h0000) begin
          ferr_addr_q <= addr_q;
          ferr_data_q <= mem.mem_data_i;
        end
        if (err_q != 16'hFFFF) err_q <= err_q + 16'h0001;
      end
    end
  end

  assign mem.mem_addr_o   = addr_q;
  assign mem.mem_data_o   = pat;
  assign mem.mem_we_o     = we;
  assign mem.mem_re_o     = re;
  assign busy_o           = (state_q == W_REQ) || (state_q == W_WAIT) ||
                            (state_q == R_REQ) || (state_q == R_WAIT);
  assign done_o           = (state_q == DONE);
  assign pass_o           = done_o && (err_q == 16'h0000) && !timeout_q;
  assign timeout_o        = timeout_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = ferr_addr_q;
  assign first_err_data_o = ferr_data_q;

endmodule
